// File: rtl/cordic_core.sv
// Single CORDIC micro-rotation stage with registered outputs, circular or hyperbolic.
// The controller owns iteration sequencing, direction choice and the angle LUT.
module cordic_core #(
  parameter int p_WIDTH = 32,
  parameter int p_SHW   = $clog2(p_WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [p_WIDTH-1:0] xprev,
  input  logic [p_WIDTH-1:0] yprev,
  input  logic [p_WIDTH-1:0] zprev,
  input  logic               dir,
  input  logic               mode,
  input  logic [p_SHW-1:0]   shift_amnt,
  input  logic [p_WIDTH-1:0] angle,
  output logic [p_WIDTH-1:0] xnext,
  output logic [p_WIDTH-1:0] ynext,
  output logic [p_WIDTH-1:0] znext,
  output logic               out_valid
);

  logic signed [p_WIDTH-1:0] xs, ys;
  logic                      x_sub;
  logic        [p_WIDTH-1:0] x_d, y_d, z_d;
  logic        [p_WIDTH-1:0] x_q, y_q, z_q;
  logic                      valid_q;

  always_comb begin
    xs = $signed(xprev) >>> shift_amnt;
    ys = $signed(yprev) >>> shift_amnt;
    // x subtracts d*ys in circular mode and adds it in hyperbolic mode.
    x_sub = (mode == dir);
    x_d = x_sub ? (xprev - $unsigned(ys)) : (xprev + $unsigned(ys));
    y_d = dir ? (yprev + $unsigned(xs)) : (yprev - $unsigned(xs));
    z_d = dir ? (zprev - angle) : (zprev + angle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= en;
      if (en) begin
        x_q <= x_d;
        y_q <= y_d;
        z_q <= z_d;
      end
    end
  end

  assign xnext     = x_q;
  assign ynext     = y_q;
  assign znext     = z_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_cordic_core.sv
// Directed self-checking bench for cordic_core: single steps, closed loops, hold and reset.
module tb_cordic_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [31:0] xprev, yprev, zprev, angle;
  logic        dir, mode;
  logic [4:0]  shift_amnt;
  logic [31:0] xnext, ynext, znext;
  logic        out_valid;

  int tests_run = 0;
  int tests_failed = 0;

  // 1e-5 and 0.001 deg expressed in Q1.31 / 2^31 == 180 deg units.
  localparam longint TolXy = 21475;
  localparam longint TolZ  = 11930;

  always #5 clk = ~clk;

  cordic_core dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .xprev      (xprev),
    .yprev      (yprev),
    .zprev      (zprev),
    .dir        (dir),
    .mode       (mode),
    .shift_amnt (shift_amnt),
    .angle      (angle),
    .xnext      (xnext),
    .ynext      (ynext),
    .znext      (znext),
    .out_valid  (out_valid)
  );

  function automatic logic [31:0] atan_lut(input int i);
    case (i)
      0:  atan_lut = 32'h20000000;
      1:  atan_lut = 32'h12E4051E;
      2:  atan_lut = 32'h09FB385B;
      3:  atan_lut = 32'h051111D4;
      4:  atan_lut = 32'h028B0D43;
      5:  atan_lut = 32'h0145D7E1;
      6:  atan_lut = 32'h00A2F61E;
      7:  atan_lut = 32'h00517C55;
      8:  atan_lut = 32'h0028BE53;
      9:  atan_lut = 32'h00145F2F;
      10: atan_lut = 32'h000A2F98;
      11: atan_lut = 32'h000517CC;
      12: atan_lut = 32'h00028BE6;
      13: atan_lut = 32'h000145F3;
      14: atan_lut = 32'h0000A2F9;
      15: atan_lut = 32'h0000517C;
      16: atan_lut = 32'h000028BE;
      17: atan_lut = 32'h0000145F;
      18: atan_lut = 32'h00000A2F;
      default: atan_lut = 32'h00000517;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                            input longint tol);
    longint diff;
    logic   ok;
    diff = longint'($signed(obs)) - longint'($signed(exp));
    ok = (diff <= tol) && (diff >= -tol);
    tests_run++;
    assert (ok === 1'b1) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h +/- %0d", tag, obs, exp, tol);
    end
  endtask

  task automatic drive(input logic m, input logic d, input logic [4:0] i, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] z, input logic [31:0] a);
    mode = m; dir = d; shift_amnt = i;
    xprev = x; yprev = y; zprev = z; angle = a;
  endtask

  // Closed-loop circular run; feeds outputs back and picks dir from z (rotation) or y (vectoring).
  task automatic run_loop(input bit vec, input logic [31:0] x0, input logic [31:0] y0,
                          input logic [31:0] z0, input int n);
    logic [31:0] x, y, z;
    x = x0; y = y0; z = z0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(1'b1, vec ? y[31] : ~z[31], 5'(i), x, y, z, atan_lut(i));
      en = 1'b1;
      @(posedge clk);
      #1;
      x = xnext; y = ynext; z = znext;
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    drive(1'b1, 1'b1, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    #12;
    check("rst_x", xnext, 32'h0);
    check("rst_y", ynext, 32'h0);
    check("rst_z", znext, 32'h0);
    check("rst_valid", {31'b0, out_valid}, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, 5'd0, 32'h40000000, 32'h0, 32'h20000000, 32'h20000000);
    en = 1'b1;
    @(posedge clk); #1;
    check("circ_x", xnext, 32'h40000000);
    check("circ_y", ynext, 32'h40000000);
    check("circ_z", znext, 32'h0);
    check("circ_valid", {31'b0, out_valid}, 32'h1);

    @(negedge clk);
    drive(1'b0, 1'b0, 5'd1, 32'h40000000, 32'h20000000, 32'h0, 32'h1661788D);
    @(posedge clk); #1;
    check("hyp_x", xnext, 32'h30000000);
    check("hyp_y", ynext, 32'h0);
    check("hyp_z", znext, 32'h1661788D);
    check("hyp_valid", {31'b0, out_valid}, 32'h1);

    @(negedge clk);
    drive(1'b1, 1'b1, 5'd31, 32'h0, 32'h80000000, 32'h0, 32'h0);
    @(posedge clk); #1;
    check("shift_x", xnext, 32'h00000001);
    check("shift_y", ynext, 32'h80000000);
    check("shift_z", znext, 32'h0);

    // Inputs change while en is low; outputs must not follow.
    @(negedge clk);
    en = 1'b0;
    drive(1'b1, 1'b1, 5'd0, 32'h40000000, 32'h0, 32'h20000000, 32'h20000000);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'b0, out_valid}, 32'h0);
    end
    check("hold_x", xnext, 32'h00000001);
    check("hold_y", ynext, 32'h80000000);
    check("hold_z", znext, 32'h0);

    run_loop(1'b0, 32'd1304065748, 32'h0, 32'h20000000, 20);
    check("rot_valid", {31'b0, out_valid}, 32'h1);
    check_near("rot_x", xnext, 32'd1518500250, TolXy);
    check_near("rot_y", ynext, 32'd1518500250, TolXy);
    check_near("rot_z", znext, 32'h0, TolZ);

    // Reset between edges partway through a loop.
    run_loop(1'b0, 32'd1304065748, 32'h0, 32'h20000000, 5);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_x", xnext, 32'h0);
    check("midrst_y", ynext, 32'h0);
    check("midrst_z", znext, 32'h0);
    check("midrst_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;

    run_loop(1'b0, 32'd1304065748, 32'h0, 32'h20000000, 20);
    check_near("rerot_x", xnext, 32'd1518500250, TolXy);
    check_near("rerot_y", ynext, 32'd1518500250, TolXy);
    check_near("rerot_z", znext, 32'h0, TolZ);

    run_loop(1'b1, 32'h0, 32'd214748365, 32'h0, 20);
    check_near("vec_x", xnext, 32'd353639073, TolXy);
    check_near("vec_y", ynext, 32'h0, TolXy);
    check_near("vec_z", znext, 32'h40000000, TolZ);

    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    check("valid_drop", {31'b0, out_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
